// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit with private HI/LO registers.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu accumulation.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] hi_q, lo_q, hi_n, lo_n;
  logic [31:0] a_q, b_q;
  logic [3:0]  op_q;
  logic        lat;
  logic        go_mul, go_div, go_mac;

  assign go_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
  assign go_div = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
`ifdef MDU_MADD_EN
  assign go_mac = (MDUOp >= OP_MADD) && (MDUOp <= OP_MSUBU);
`else
  assign go_mac = 1'b0;
`endif

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        a_mag, b_mag, qm, rm;
  logic [31:0]        q_s, r_s, q_u, r_u;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) *
                  $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes so INT_MIN / -1 wraps cleanly.
  assign a_mag = a_q[31] ? (~a_q + 32'd1) : a_q;
  assign b_mag = b_q[31] ? (~b_q + 32'd1) : b_q;
  assign qm    = a_mag / b_mag;
  assign rm    = a_mag % b_mag;
  assign q_s   = (a_q[31] ^ b_q[31]) ? (~qm + 32'd1) : qm;
  assign r_s   = a_q[31] ? (~rm + 32'd1) : rm;
  assign q_u   = a_q / b_q;
  assign r_u   = a_q % b_q;

  logic [31:0] res_hi, res_lo;

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV:   if (b_q != 32'd0) begin
        res_hi = r_s;
        res_lo = q_s;
      end
      OP_DIVU:  if (b_q != 32'd0) begin
        res_hi = r_u;
        res_lo = q_u;
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
      OP_MADDU: {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
      OP_MSUB:  {res_hi, res_lo} = {hi_q, lo_q} - prod_s;
      OP_MSUBU: {res_hi, res_lo} = {hi_q, lo_q} - prod_u;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi_q;
    lo_n    = lo_q;
    lat     = 1'b0;
    if (state == S_RUN) begin
      cnt_n = cnt - 32'd1;
      if (cnt == 32'd1) begin
        state_n = S_IDLE;
        hi_n    = res_hi;
        lo_n    = res_lo;
      end
    end
    // The completion edge counts as idle, so a new op may start there.
    if (state_n == S_IDLE && Start) begin
      if (go_mul || go_div || go_mac) begin
        lat     = 1'b1;
        state_n = S_RUN;
        cnt_n   = go_div ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
      end else if (MDUOp == OP_MTHI) begin
        hi_n = A;
      end else if (MDUOp == OP_MTLO) begin
        lo_n = A;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      if (lat) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= MDUOp;
      end
    end
  end

  assign Busy = (state == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit with its own HI/LO register pair. It sits beside the ALU in E and produces the `mfhi`/`mflo` values that the E-stage result mux forwards into `E_C`, which then goes into the E→M pipeline register. Multiply and divide run as multi-cycle operations tracked by a down-counter and a `Busy` flag. The hazard unit uses `Start | Busy` to stall any later MDU instruction in D.

## Interface
- `MULT_CYCLES`, default 5: cycles `Busy` stays high for mult/multu (and for madd-class ops when enabled); must be ≥1.
- `DIV_CYCLES`, default 10: cycles `Busy` stays high for div/divu; must be ≥1.
- `clk` in 1: the single clock; every state change happens on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `Start` in 1: one-cycle request qualifying `MDUOp` for the instruction currently in E.
- `MDUOp` in 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11–15 reserved.
- `A` in 32: forwarded rs value.
- `B` in 32: forwarded rt value.
- `Busy` out 1: an operation is in flight.
- `HI` out 32: architectural HI.
- `LO` out 32: architectural LO.

## Operation
- Reset, asynchronous: `HI`=0, `LO`=0, `Busy`=0, counter=0, operand latches=0. Any in-flight operation is aborted and its result is never written.
- Two states:
  - IDLE (`Busy`=0).
  - RUN (`Busy`=1, counter holds the remaining cycles).
- IDLE, rising edge with `Start`=1:
  - ops 1–4 and 7–10: latch `A`, `B` and `MDUOp`; load counter with `MULT_CYCLES` or `DIV_CYCLES`; go to RUN.
  - op 5: `HI`←`A` at that edge; stay in IDLE.
  - op 6: `LO`←`A` at that edge; stay in IDLE.
  - ops 0 and 11–15: no effect.
- RUN: the counter decrements each edge. On the edge where counter==1:
  - write `HI`/`LO` from the latched operands;
  - `Busy`←0; go to IDLE.
- `Start` while in RUN is ignored, including mthi/mtlo. The hazard unit guarantees this never happens; the bench checks that it is harmless.
- HI/LO hold their old values throughout RUN. Results come only from the latched operands, never from the live `A`/`B`.
- Arithmetic:
  - mult: {HI,LO} = `$signed(A)*$signed(B)`, full 64-bit result.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder, whose sign follows the dividend.
  - divu: LO = unsigned quotient; HI = unsigned remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B==0, div or divu): runs the full `DIV_CYCLES` with `Busy` high. HI and LO are left unchanged.

## Timing
- Start accepted at edge t: `Busy`=1 from t through t+N−1. At edge t+N, `Busy` falls and the new HI/LO become visible in the same cycle (N = configured cycle count).
- mthi/mtlo accepted at edge t: the new value is visible right after t. Back-to-back mthi then mtlo in consecutive cycles both take effect.
- A new operation may start on the very edge where `Busy` falls. In that case the old result is written and the new operands are latched on the same edge.
- `HI`, `LO` and `Busy` are driven directly by registers; there is no combinational path from the inputs to the outputs.
- Reset asserted mid-RUN: the outputs go to their reset values without waiting for a clock edge. After reset is released, the block is in IDLE and accepts a Start on the first edge.

## Configuration
- `MDU_MADD_EN` defined:
  - ops 7–10 run for `MULT_CYCLES`.
  - madd: {HI,LO} += signed product. maddu: {HI,LO} += unsigned product.
  - msub: {HI,LO} −= signed product. msubu: {HI,LO} −= unsigned product.
  - All use modulo-2^64 arithmetic and the {HI,LO} value present at the completion edge.
- `MDU_MADD_EN` undefined: ops 7–10 behave exactly like op 0 (no RUN, no Busy, HI/LO unchanged).

## Test plan
- Reset, then mult with A=0xFFFFFFFE (−2), B=3 → `Busy` high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu → HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (−7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 after mthi 0x11 / mtlo 0x22 → Busy for 10 cycles, then HI=0x11, LO=0x22.
- Start mult, then change A/B and pulse Start with mtlo 0x55 during RUN → both ignored; result matches the original operands.
- Assert reset 3 cycles into a div → Busy=0, HI=LO=0 immediately; a following mult 6×7 yields LO=42, HI=0.
- Issue multu 0xFFFFFFFF×0xFFFFFFFF, then start div 100/7 on the edge where Busy falls → HI=0xFFFFFFFE, LO=0x00000001. Ten cycles later LO=14, HI=2.
- With `MDU_MADD_EN`: mthi 0, mtlo 0xFFFFFFFF, then maddu 1×1 → HI=1, LO=0. Without the macro: the same op leaves HI=0, LO=0xFFFFFFFF and never asserts Busy.
